fetch_unit: RTL and testbench

Instruction fetch stage for the WISC-SP16 single-issue pipeline. It owns the PC, requests 16-bit instructions from instruction memory and latches them into the instruction register. It presents `opcode` (bits 15:11) and `func` (bits 1:0) to the control unit. It also handles halt, `siic` exception entry and `rti` return, and accepts stalls and branch/jump redirects from later stages.

---
 rtl/wisc_pkg.sv | 20 ++
 rtl/reg16_en.sv | 28 ++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared WISC-SP16 definitions: instruction width, special opcodes and the
// fetch-stage state type.
package wisc_pkg;

    localparam int INSTR_W = 16;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_SIIC = 5'b00010;
    localparam logic [4:0] OP_RTI  = 5'b00011;

    // A NOP with all operand fields zero; used as the pipeline bubble.
    localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, 11'b0};

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/reg16_en.sv
// 16-bit register with a synchronous reset value and a load enable.
module reg16_en
    import wisc_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RST_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic [INSTR_W-1:0] i_d,
    output logic [INSTR_W-1:0] o_q
);

    logic [INSTR_W-1:0] r_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// WISC-SP16 instruction fetch stage: PC, instruction register, halt,
// siic/rti control flow, stalls and redirects.
module fetch_unit
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] EXC_VEC  = 16'h0002
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic [15:0] imem_data,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr,
    output logic [4:0]  opcode,
    output logic [1:0]  func,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
    output logic        halted,
    output logic [15:0] epc
);

    fetch_state_t        r_state;
    logic                r_instr_valid;

    logic [INSTR_W-1:0]  w_pc;
    logic [INSTR_W-1:0]  w_pc_inc;
    logic [INSTR_W-1:0]  w_pc_d;
    logic [INSTR_W-1:0]  w_instr_d;
    logic [4:0]          w_fetch_op;
    logic                w_req;
    logic                w_fire;
    logic                w_pc_en;
    logic                w_instr_en;
    logic                w_epc_en;

    assign w_pc_inc   = w_pc + 16'd2;
    assign w_req      = (r_state == ST_FETCH) & ~stall & ~rst;
    assign w_fire     = w_req & imem_valid & ~redirect;
    assign w_fetch_op = imem_data[15:11];

    // NOTE: the default assignment first keeps this block latch-free.
    always_comb begin
        w_pc_d = w_pc_inc;
        if (redirect) begin
            w_pc_d = redirect_pc;
        end else if (w_fetch_op == OP_SIIC) begin
            w_pc_d = EXC_VEC;
        end else if (w_fetch_op == OP_RTI) begin
            w_pc_d = epc;
        end
    end

    // The PC moves only on a completed fetch or a redirect.
    assign w_pc_en    = redirect | w_fire;
    // Redirect overrides a stall; otherwise any unstalled cycle loads
    // either the fetched word or the bubble.
    assign w_instr_en = redirect | ~stall;
    assign w_instr_d  = w_fire ? imem_data : NOP_INSTR;
    assign w_epc_en   = w_fire & (w_fetch_op == OP_SIIC);

    reg16_en #(.RST_VAL(RESET_PC)) u_pc (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_pc_en),
        .i_d  (w_pc_d),
        .o_q  (w_pc)
    );

    reg16_en #(.RST_VAL(NOP_INSTR)) u_instr (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_instr_en),
        .i_d  (w_instr_d),
        .o_q  (instr)
    );

    reg16_en #(.RST_VAL(16'h0000)) u_pc_plus2 (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_fire),
        .i_d  (w_pc_inc),
        .o_q  (pc_plus2)
    );

    reg16_en #(.RST_VAL(16'h0000)) u_epc (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_epc_en),
        .i_d  (w_pc_inc),
        .o_q  (epc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_FETCH;
            r_instr_valid <= 1'b0;
        end else if (redirect) begin
            r_state       <= ST_FETCH;
            r_instr_valid <= 1'b0;
        end else if (!stall) begin
            r_instr_valid <= w_fire;
            if (w_fire && (w_fetch_op == OP_HALT)) begin
                r_state <= ST_HALT;
            end
        end
    end

    assign imem_addr   = w_pc;
    assign imem_req    = w_req;
    assign instr_valid = r_instr_valid;
    assign halted      = (r_state == ST_HALT);
    assign opcode      = instr[15:11];
    assign func        = instr[1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed stimulus, a behavioural
// model compared every cycle, plus hand-computed literal expectations.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr;
    logic [4:0]  opcode;
    logic [1:0]  func;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        halted;
    logic [15:0] epc;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];

    // Model state
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic        m_valid;
    logic [15:0] m_pp2;
    logic [15:0] m_epc;
    logic        m_halted;
    logic [15:0] m_word;

    fetch_unit #(.RESET_PC(16'h0000), .EXC_VEC(16'h0002)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_data   (imem_data),
        .imem_valid  (imem_valid),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .opcode      (opcode),
        .func        (func),
        .pc_plus2    (pc_plus2),
        .instr_valid (instr_valid),
        .halted      (halted),
        .epc         (epc)
    );

    // Invalid data reads as a halt word, so ignoring imem_valid is caught.
    assign imem_data = imem_valid ? mem[imem_addr[8:1]] : 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one rule per input condition, in priority order.
    always @(posedge clk) begin
        if (rst) begin
            m_pc = 16'h0000; m_instr = 16'h0800; m_valid = 1'b0;
            m_pp2 = 16'h0000; m_epc = 16'h0000; m_halted = 1'b0;
        end else if (redirect) begin
            m_pc = redirect_pc; m_instr = 16'h0800; m_valid = 1'b0; m_halted = 1'b0;
        end else if (stall) begin
            m_valid = m_valid;
        end else if (!m_halted && imem_valid) begin
            m_word  = mem[m_pc[8:1]];
            m_instr = m_word;
            m_valid = 1'b1;
            m_pp2   = m_pc + 16'd2;
            case (m_word[15:11])
                5'b00000: begin m_halted = 1'b1; m_pc = m_pc + 16'd2; end
                5'b00010: begin m_epc = m_pc + 16'd2; m_pc = 16'h0002; end
                5'b00011: m_pc = m_epc;
                default:  m_pc = m_pc + 16'd2;
            endcase
        end else begin
            m_instr = 16'h0800; m_valid = 1'b0;
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        check("imem_addr",   imem_addr,   m_pc);
        check("imem_req",    imem_req,    16'(!m_halted && !stall && !rst));
        check("instr",       instr,       m_instr);
        check("opcode",      opcode,      16'(m_instr[15:11]));
        check("func",        func,        16'(m_instr[1:0]));
        check("instr_valid", instr_valid, 16'(m_valid));
        check("pc_plus2",    pc_plus2,    m_pp2);
        check("halted",      halted,      16'(m_halted));
        check("epc",         epc,         m_epc);
    end

    // Apply inputs for one edge; returns 1 time unit after that edge.
    task automatic drive(input logic r, input logic v, input logic s,
                         input logic rd, input logic [15:0] rpc);
        rst = r; imem_valid = v; stall = s; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h4000 | 16'(i << 1);
        mem[16'h0020 >> 1] = 16'h1000;  // siic
        mem[16'h0030 >> 1] = 16'h0000;  // halt
        mem[16'h0050 >> 1] = 16'h1800;  // rti

        m_pc = 16'h0000; m_instr = 16'h0800; m_valid = 1'b0;
        m_pp2 = 16'h0000; m_epc = 16'h0000; m_halted = 1'b0; m_word = 16'h0000;

        drive(1, 1, 0, 0, 16'h0);
        drive(1, 0, 0, 0, 16'h0);
        check("rst addr", imem_addr, 16'h0000);
        check("rst instr", instr, 16'h0800);
        check("rst valid", instr_valid, 16'h0);
        check("rst halted", halted, 16'h0);

        drive(0, 1, 0, 0, 16'h0);
        check("seq addr1", imem_addr, 16'h0002);
        check("seq instr1", instr, 16'h4000);
        check("seq valid1", instr_valid, 16'h1);
        drive(0, 1, 0, 0, 16'h0);
        check("seq addr2", imem_addr, 16'h0004);
        check("seq instr2", instr, 16'h4002);
        drive(0, 1, 0, 0, 16'h0);
        check("seq addr3", imem_addr, 16'h0006);
        check("seq pp2", pc_plus2, 16'h0006);

        drive(0, 0, 0, 1, 16'h0010);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 16'h0);
            check("wait addr", imem_addr, 16'h0010);
            check("wait bubble", instr, 16'h0800);
            check("wait valid", instr_valid, 16'h0);
        end
        drive(0, 1, 0, 0, 16'h0);
        check("late instr", instr, 16'h4010);
        check("late addr", imem_addr, 16'h0012);

        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 16'h0);
            check("stall instr", instr, 16'h4010);
            check("stall addr", imem_addr, 16'h0012);
            check("stall pp2", pc_plus2, 16'h0012);
        end
        drive(0, 1, 0, 0, 16'h0);
        check("resume instr", instr, 16'h4012);
        check("resume addr", imem_addr, 16'h0014);

        drive(0, 1, 1, 1, 16'h0100);
        check("redir+stall addr", imem_addr, 16'h0100);
        check("redir+stall instr", instr, 16'h0800);

        drive(0, 0, 0, 1, 16'h0020);
        drive(0, 1, 0, 0, 16'h0);
        check("siic instr", instr, 16'h1000);
        check("siic epc", epc, 16'h0022);
        check("siic addr", imem_addr, 16'h0002);
        drive(0, 1, 0, 0, 16'h0);
        check("vec instr", instr, 16'h4002);

        drive(0, 0, 0, 1, 16'hFFFE);
        drive(0, 1, 0, 0, 16'h0);
        check("wrap addr", imem_addr, 16'h0000);
        check("wrap pp2", pc_plus2, 16'h0000);

        drive(0, 0, 0, 1, 16'h0050);
        drive(0, 1, 0, 0, 16'h0);
        check("rti instr", instr, 16'h1800);
        check("rti addr", imem_addr, 16'h0022);

        drive(0, 0, 0, 1, 16'h0061);
        check("odd addr", imem_addr, 16'h0061);
        drive(0, 1, 0, 0, 16'h0);
        check("odd next", imem_addr, 16'h0063);

        drive(0, 0, 0, 1, 16'h0030);
        drive(0, 1, 0, 0, 16'h0);
        check("halt instr", instr, 16'h0000);
        check("halt flag", halted, 16'h1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 16'h0);
            check("halt hold", halted, 16'h1);
            check("halt req", imem_req, 16'h0);
        end
        drive(0, 0, 0, 1, 16'h0040);
        check("unhalt flag", halted, 16'h0);
        check("unhalt addr", imem_addr, 16'h0040);
        drive(0, 1, 0, 0, 16'h0);
        check("unhalt instr", instr, 16'h4040);

        drive(0, 0, 0, 1, 16'h0030);
        drive(0, 1, 0, 0, 16'h0);
        drive(1, 1, 0, 0, 16'h0);
        check("rst halt flag", halted, 16'h0);
        check("rst halt addr", imem_addr, 16'h0000);
        check("rst halt instr", instr, 16'h0800);
        drive(0, 1, 0, 0, 16'h0);
        check("post rst addr", imem_addr, 16'h0002);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
